// File: rtl/ce_pkg.sv
// rtl/ce_pkg.sv - shared types and constants for the CE sequencer
// Purpose: sequencer state encoding, weight-bus width helper and the CE
//          output-width growth constants shared by the CE-facing blocks.
// Ports:   none (package).
package ce_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT_W = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_t;

    // Width of one packed weight word: every channel, every kernel tap.
    function automatic int ce_w_width(input int cl_in, input int kernel, input int m);
        return cl_in * kernel * kernel * m;
    endfunction

    localparam int CE_CL_IN  = 14;
    localparam int CE_KERNEL = 7;

    // Extra result bits from summing the kernel window (E1) and the channels (E2).
    localparam int E1 = $clog2(CE_KERNEL * CE_KERNEL);
    localparam int E2 = $clog2(CE_CL_IN);

endpackage

// File: rtl/ce_credit_cnt.sv
// rtl/ce_credit_cnt.sv - bounded up/down counter with misuse detection
// Purpose: counts up on i_inc and down on i_dec, holding at 0 and MAX.
//          A step that would leave [0, MAX] is dropped and flagged on o_err.
// Ports:   i_clk, i_rst (sync, active-high)
//          i_inc, i_dec   count strobes; both together leave the count unchanged
//          o_cnt          current count
//          o_err          one-cycle flag for a dropped overflow/underflow step
module ce_credit_cnt #(
    parameter int MAX  = 8,
    parameter int INIT = 0,
    parameter int W    = $clog2(MAX + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_err
);

    logic [W-1:0] r_cnt;
    logic         w_ovf;
    logic         w_unf;

    assign w_ovf = i_inc && !i_dec && (r_cnt == W'(MAX));
    assign w_unf = i_dec && !i_inc && (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= W'(INIT);
        end else if (i_inc && !i_dec && !w_ovf) begin
            r_cnt <= r_cnt + W'(1);
        end else if (i_dec && !i_inc && !w_unf) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_err = w_ovf | w_unf;

endmodule

// File: rtl/ce_seq_ctrl.sv
// rtl/ce_seq_ctrl.sv - filter/pixel tile sequencer for one CE engine
// Purpose: loads one weight word per filter, issues pixel windows to CE under
//          result-buffer credits, drains CE before each weight change and
//          tags every CE result with its filter and pixel index.
// Ports:   i_clk, i_rst (sync, active-high)
//          i_start, i_num_filt, i_num_pix, o_busy, o_done     tile control
//          i_win_valid, o_win_ready                           window source
//          o_w_rd, o_w_addr, i_w_rdata                        weight memory
//          o_w, o_ce_en_in, i_ce_en_out                       CE engine
//          o_res_valid, o_res_filt, o_res_pix, i_credit_ret   result FIFO
//          o_err                                              sticky protocol error
module ce_seq_ctrl
    import ce_pkg::*;
#(
    parameter  int CL_IN  = 14,
    parameter  int KERNEL = 7,
    parameter  int M      = 4,
    parameter  int FILT_W = 8,
    parameter  int PIX_W  = 16,
    parameter  int CRED   = 8,
    localparam int WW     = ce_w_width(CL_IN, KERNEL, M)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [FILT_W-1:0] i_num_filt,
    input  logic [PIX_W-1:0]  i_num_pix,
    output logic              o_busy,
    output logic              o_done,
    input  logic              i_win_valid,
    output logic              o_win_ready,
    output logic              o_w_rd,
    output logic [FILT_W-1:0] o_w_addr,
    input  logic [WW-1:0]     i_w_rdata,
    output logic [WW-1:0]     o_w,
    output logic              o_ce_en_in,
    input  logic              i_ce_en_out,
    output logic              o_res_valid,
    output logic [FILT_W-1:0] o_res_filt,
    output logic [PIX_W-1:0]  o_res_pix,
    input  logic              i_credit_ret,
    output logic              o_err
);

    localparam int CW = $clog2(CRED + 1);

    seq_state_t        r_state, w_state_nxt;
    logic [FILT_W-1:0] r_num_filt, r_f_cnt, r_res_filt;
    logic [PIX_W-1:0]  r_num_pix, r_pix_cnt, r_res_pix;
    logic [WW-1:0]     r_w;
    logic              r_err;
    logic [CW-1:0]     w_credits, w_inflight;
    logic              w_cred_err, w_infl_err;
    logic              w_issue, w_last_issue, w_drained, w_last_filt;
    logic              w_res_ok, w_res_wrap, w_empty_tile;

    assign o_win_ready  = (r_state == ST_RUN) && (w_credits != '0) && (r_pix_cnt < r_num_pix);
    assign w_issue      = i_win_valid && o_win_ready;
    assign o_ce_en_in   = w_issue;
    assign w_last_issue = w_issue && (r_pix_cnt == r_num_pix - PIX_W'(1));
    // A result retiring this cycle counts, so DRAIN exits right after the last result.
    assign w_drained    = (w_inflight == '0) || ((w_inflight == CW'(1)) && i_ce_en_out);
    assign w_last_filt  = (r_f_cnt == r_num_filt - FILT_W'(1));
    assign w_res_ok     = i_ce_en_out && !w_infl_err;
    assign w_res_wrap   = (r_res_pix == r_num_pix - PIX_W'(1));
    assign w_empty_tile = (i_num_filt == '0) || (i_num_pix == '0);

    ce_credit_cnt #(.MAX(CRED), .INIT(CRED)) u_credits (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (i_credit_ret),
        .i_dec (w_issue),
        .o_cnt (w_credits),
        .o_err (w_cred_err)
    );

    ce_credit_cnt #(.MAX(CRED), .INIT(0)) u_inflight (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_issue),
        .i_dec (i_ce_en_out),
        .o_cnt (w_inflight),
        .o_err (w_infl_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (i_start) w_state_nxt = w_empty_tile ? ST_DONE : ST_LOAD;
            ST_LOAD:   w_state_nxt = ST_WAIT_W;
            ST_WAIT_W: w_state_nxt = ST_RUN;
            ST_RUN:    if (w_last_issue) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (w_drained) w_state_nxt = w_last_filt ? ST_DONE : ST_LOAD;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_num_filt <= '0;
            r_num_pix  <= '0;
            r_f_cnt    <= '0;
            r_pix_cnt  <= '0;
            r_res_filt <= '0;
            r_res_pix  <= '0;
            r_w        <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= r_err | w_cred_err | w_infl_err;
            // Weights only move here, after DRAIN has emptied CE.
            if (r_state == ST_WAIT_W) r_w <= i_w_rdata;
            if (w_issue) r_pix_cnt <= r_pix_cnt + PIX_W'(1);
            if ((r_state == ST_DRAIN) && w_drained && !w_last_filt) begin
                r_f_cnt   <= r_f_cnt + FILT_W'(1);
                r_pix_cnt <= '0;
            end
            if (w_res_ok) begin
                if (w_res_wrap) begin
                    r_res_pix  <= '0;
                    r_res_filt <= r_res_filt + FILT_W'(1);
                end else begin
                    r_res_pix  <= r_res_pix + PIX_W'(1);
                end
            end
            // Tile launch comes last so its clears take priority.
            if ((r_state == ST_IDLE) && i_start) begin
                r_num_filt <= i_num_filt;
                r_num_pix  <= i_num_pix;
                r_f_cnt    <= '0;
                r_pix_cnt  <= '0;
                r_res_filt <= '0;
                r_res_pix  <= '0;
            end
        end
    end

    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_w_rd      = (r_state == ST_LOAD);
    assign o_w_addr    = r_f_cnt;
    assign o_w         = r_w;
    assign o_res_valid = i_ce_en_out;
    assign o_res_filt  = r_res_filt;
    assign o_res_pix   = r_res_pix;
    assign o_err       = r_err;

endmodule

// File: doc/ce_seq_ctrl.md
# ce_seq_ctrl

Sequencer for one CE convolution engine. It walks a tile of `num_filt` filters × `num_pix` output pixels, filter-outer and pixel-inner. For each filter it loads one weight word from weight memory into a held weight register, then issues pixel windows to CE under a credit limit set by the downstream result buffer. It drains CE before changing weights and tags every CE result with its filter and pixel index. It sits between the window buffer, weight memory, CE and the result FIFO.

## Interface
- `CL_IN`, 14, input channels per window (same as CE).
- `KERNEL`, 7, kernel size 1/3/5/7 (same as CE).
- `M`, 4, weight width.
- `FILT_W`, 8, filter counter and weight-address width.
- `PIX_W`, 16, pixel counter width.
- `CRED`, 8, result-buffer depth, i.e. the initial credit count; range 1..255.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch a tile; sampled only in IDLE.
- `num_filt`  in  FILT_W  filters in the tile; latched on start.
- `num_pix`  in  PIX_W  pixels per filter; latched on start.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the tile is complete.
- `win_valid`  in  1  window source has a window on CE `data2conv`.
- `win_ready`  out  1  controller accepts the window this cycle.
- `w_rd`  out  1  weight memory read strobe.
- `w_addr`  out  FILT_W  weight memory address, equal to the current filter index.
- `w_rdata`  in  CL_IN*KERNEL*KERNEL*M  read data, valid 1 cycle after `w_rd`.
- `w`  out  CL_IN*KERNEL*KERNEL*M  held weight bus to CE `w`.
- `ce_en_in`  out  1  issue strobe to CE `en_in`.
- `ce_en_out`  in  1  CE result strobe.
- `res_valid`  out  1  equals `ce_en_out`, combinational.
- `res_filt`  out  FILT_W  filter tag of the current result.
- `res_pix`  out  PIX_W  pixel tag of the current result.
- `credit_ret`  in  1  downstream freed one result entry.
- `err`  out  1  sticky protocol error flag, cleared only by `rst`.

## Operation
- States: IDLE, LOAD, WAIT_W, RUN, DRAIN, DONE.
- IDLE → LOAD on `start`. On that edge: latch `num_filt` and `num_pix`; clear `f_cnt`, `pix_cnt`, `res_filt` and `res_pix`.
- IDLE → DONE instead if `num_filt`==0 or `num_pix`==0. No read and no issue occur.
- LOAD: `w_rd`=1 and `w_addr`=`f_cnt`. Go to WAIT_W.
- WAIT_W: register `w` ← `w_rdata`. Go to RUN.
- RUN: `win_ready` = (credits≠0) && (`pix_cnt`<`num_pix`). `ce_en_in` = `win_valid` && `win_ready`.
- On each issue: `pix_cnt`++, credits−−, inflight++.
- RUN → DRAIN in the cycle of the last issue, i.e. when `pix_cnt` reaches `num_pix`.
- DRAIN: wait until inflight==0.
  - If `f_cnt`==`num_filt`−1, go to DONE.
  - Otherwise `f_cnt`++, `pix_cnt`←0, go to LOAD.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `w` changes only in WAIT_W, so CE never sees a weight change while inflight≠0.
- Credits: reset value CRED.
  - Issue alone: −1. `credit_ret` alone: +1. Both in the same cycle: unchanged.
  - `credit_ret` while credits==CRED is ignored and sets `err`.
- Inflight: +1 on issue, −1 on `ce_en_out`; unchanged if both occur in the same cycle.
  - `ce_en_out` while inflight==0 is dropped and sets `err`.
- Tags advance on `ce_en_out`: `res_pix`++.
  - When `res_pix`==`num_pix`−1, `res_pix`←0 and `res_filt`++.
  - The tags shown during a `res_valid` cycle are the values before the increment.
- `start` while not in IDLE is ignored.
- `rst` in any state:
  - returns to IDLE;
  - clears all counters, `w` and `err`;
  - reloads credits to CRED;
  - CE results still in flight are not tracked.

## Timing
- Reset values: `busy`, `done`, `win_ready`, `ce_en_in`, `w_rd`, `err`=0; `w_addr`, `w`, `res_filt`, `res_pix`=0.
- `start` at cycle t: LOAD at t+1 (`w_rd`), WAIT_W at t+2, RUN at t+3. The first issue is possible at t+3.
- Filter switch overhead: DRAIN waits the CE latency after the last issue, then 2 cycles (LOAD, WAIT_W) before RUN.
- `done` asserts the cycle after the tile's final `ce_en_out`; IDLE follows on the next cycle.
- `win_ready` and `ce_en_in` are combinational from state, counters and `win_valid`. All other outputs are registered, except `res_*`, where `res_valid` follows `ce_en_out` combinationally.
- Peak throughput: 1 issue per cycle while credits≠0.

## Structure
- Shared package `ce_pkg` holds:
  - the state encoding;
  - the weight-bus width function CL_IN*KERNEL²*M;
  - the CE output-width growth constants E1 (from KERNEL) and E2 (from CL_IN).
- One sub-module, `ce_credit_cnt`: an up/down counter with parameterised max, saturating guards and an overflow/underflow error output. It is instantiated twice: once for credits and once for inflight, with max = CRED.

## Test plan
- `num_filt`=2, `num_pix`=3, `win_valid` always 1, `credit_ret` returned 1 cycle after each result, CE model with latency 4:
  - exactly 6 issues and `w_addr` 0 then 1;
  - tags in order (0,0)(0,1)(0,2)(1,0)(1,1)(1,2);
  - one `done` pulse and `err`=0.
- CRED=2, `num_pix`=5, no `credit_ret`: exactly 2 issues, then `win_ready`=0 indefinitely. Returning 1 credit allows exactly 1 more issue.
- `num_pix`=0: `start` → `done` pulses the next cycle; `w_rd` and `ce_en_in` are never asserted.
- `win_valid` toggling 1010…, `num_pix`=4: issues occur only in cycles where `win_valid`=1. Check that `w` is unchanged from WAIT_W until inflight==0, i.e. it never changes during DRAIN.
- Error cases:
  - a spurious `ce_en_out` in IDLE sets `err` and leaves inflight at 0;
  - `credit_ret` at full credits sets `err`;
  - a second `start` while busy is ignored.
- `rst` asserted in the second cycle of RUN: the next cycle is IDLE with all outputs at reset values and credits at CRED. A following `start` completes a full tile normally.
